// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one memory port between I-cache and D-cache block
// transfers and a DMA BR/BG handshake, with a one-cycle gap after every owner.
module mem_bus_arbiter #(
  parameter int WORD_SIZE   = 16,
  parameter int LATENCY     = 4,
  parameter int BLOCK_WORDS = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           i_req,
  input  logic [WORD_SIZE-1:0]           i_addr,
  input  logic                           d_req,
  input  logic                           d_we,
  input  logic [WORD_SIZE-1:0]           d_addr,
  input  logic                           br,
  output logic                           bg,
  output logic                           i_grant,
  output logic                           d_grant,
  output logic                           i_done,
  output logic                           d_done,
  output logic                           word_valid,
  output logic [$clog2(BLOCK_WORDS)-1:0] word_idx,
  output logic                           mem_read,
  output logic                           mem_write,
  output logic [WORD_SIZE-1:0]           mem_addr
);
  localparam int IW = $clog2(BLOCK_WORDS);
  localparam int LW = LATENCY > 1 ? $clog2(LATENCY) : 1;
  typedef enum logic [2:0] {IDLE, D_XFER, I_XFER, DMA, GAP} state_t;
  state_t         state_q, state_d;
  logic [LW-1:0]  lat_q, lat_d;
  logic [IW-1:0]  idx_q, idx_d;
  logic           turn_q, turn_d, we_q, we_d, xfer, last;
  logic [WORD_SIZE-1:0] base_q, base_d;
  always_comb begin
    state_d = state_q;
    lat_d   = lat_q;
    idx_d   = idx_q;
    turn_d  = turn_q;
    base_d  = base_q;
    we_d    = we_q;
    xfer       = state_q == D_XFER || state_q == I_XFER;
    word_valid = xfer && lat_q == LW'(LATENCY - 1);
    last       = word_valid && idx_q == IW'(BLOCK_WORDS - 1);
    case (state_q)
      IDLE:
        if (br && (turn_q || (!d_req && !i_req))) begin
          state_d = DMA;
          turn_d  = 1'b0;
        end else if (d_req || i_req) begin
          state_d = d_req ? D_XFER : I_XFER;
          base_d  = d_req ? d_addr : i_addr;
          we_d    = d_we;
          lat_d   = '0;
          idx_d   = '0;
        end
      D_XFER, I_XFER: begin
        lat_d = word_valid ? '0 : lat_q + LW'(1);
        idx_d = idx_q + IW'(word_valid);
        if (last) begin
          state_d = GAP;
          turn_d  = turn_q | br;
        end
      end
      DMA:     state_d = br ? DMA : GAP;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      lat_q   <= '0;
      idx_q   <= '0;
      turn_q  <= 1'b0;
      base_q  <= '0;
      we_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      lat_q   <= lat_d;
      idx_q   <= idx_d;
      turn_q  <= turn_d;
      base_q  <= base_d;
      we_q    <= we_d;
    end
  end
  assign bg        = state_q == DMA;
  assign i_grant   = state_q == I_XFER;
  assign d_grant   = state_q == D_XFER;
  assign i_done    = last && i_grant;
  assign d_done    = last && d_grant;
  assign word_idx  = xfer ? idx_q : '0;
  assign mem_write = d_grant && we_q;
  assign mem_read  = xfer && !mem_write;
  assign mem_addr  = xfer ? (base_q & ~WORD_SIZE'(BLOCK_WORDS - 1)) | WORD_SIZE'(idx_q) : '0;
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: directed scenario tasks for the arbiter, one default
// instance and one LATENCY=1 / BLOCK_WORDS=8 instance sharing clock and reset.
module tb_mem_bus_arbiter;
  logic clk = 0, reset = 0;
  logic i_req = 0, d_req = 0, d_we = 0, br = 0;
  logic [15:0] i_addr = 0, d_addr = 0;
  logic bg, i_grant, d_grant, i_done, d_done, word_valid, mem_read, mem_write;
  logic [1:0] word_idx;
  logic [15:0] mem_addr;
  logic i2_req = 0;
  logic [15:0] i2_addr = 0;
  logic bg2, i_grant2, d_grant2, i_done2, d_done2, word_valid2, mem_read2, mem_write2;
  logic [2:0] word_idx2;
  logic [15:0] mem_addr2;
  logic [26:0] outs;
  int pass_n = 0, total_n = 0;

  assign outs = {bg, i_grant, d_grant, i_done, d_done, word_valid, word_idx,
                 mem_read, mem_write, mem_addr};

  always #5 clk = ~clk;

  mem_bus_arbiter dut (
    .clk(clk), .reset(reset), .i_req(i_req), .i_addr(i_addr), .d_req(d_req),
    .d_we(d_we), .d_addr(d_addr), .br(br), .bg(bg), .i_grant(i_grant),
    .d_grant(d_grant), .i_done(i_done), .d_done(d_done), .word_valid(word_valid),
    .word_idx(word_idx), .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr)
  );

  mem_bus_arbiter #(.WORD_SIZE(16), .LATENCY(1), .BLOCK_WORDS(8)) dut2 (
    .clk(clk), .reset(reset), .i_req(i2_req), .i_addr(i2_addr), .d_req(1'b0),
    .d_we(1'b0), .d_addr(16'h0), .br(1'b0), .bg(bg2), .i_grant(i_grant2),
    .d_grant(d_grant2), .i_done(i_done2), .d_done(d_done2), .word_valid(word_valid2),
    .word_idx(word_idx2), .mem_read(mem_read2), .mem_write(mem_write2), .mem_addr(mem_addr2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1;
    tick();
    tick();
    reset = 0;
    total_n++;
    if (outs !== 27'd0) $display("FAIL reset_outs: got %h want 0", outs); else pass_n++;
    total_n++;
    if ({bg2, i_grant2, d_grant2, word_valid2, mem_read2, mem_write2, mem_addr2} !== 22'd0)
      $display("FAIL reset_outs2: got %b want 0", {bg2, i_grant2, mem_addr2}); else pass_n++;
  endtask

  task automatic test_i_fill();
    i_req = 1;
    i_addr = 16'h0012;
    tick();
    for (int k = 0; k < 16; k++) begin
      total_n++;
      if ({i_grant, d_grant, mem_read, mem_write, bg} !== 5'b10100)
        $display("FAIL i_fill_ctl[%0d]: got %b want 10100", k, {i_grant, d_grant, mem_read, mem_write, bg});
      else pass_n++;
      total_n++;
      if (mem_addr !== 16'h0010 + 16'(k / 4) || word_idx !== 2'(k / 4))
        $display("FAIL i_fill_addr[%0d]: got %h/%0d want %h/%0d", k, mem_addr, word_idx, 16'h0010 + 16'(k / 4), k / 4);
      else pass_n++;
      total_n++;
      if (word_valid !== (k % 4 == 3) || i_done !== (k == 15) || d_done !== 1'b0)
        $display("FAIL i_fill_pulse[%0d]: got wv=%b done=%b want wv=%b done=%b", k, word_valid, i_done, k % 4 == 3, k == 15);
      else pass_n++;
      if (k == 15) i_req = 0;
      tick();
    end
    total_n++;
    if (outs !== 27'd0) $display("FAIL i_fill_gap: got %h want 0", outs); else pass_n++;
    tick();
  endtask

  task automatic test_d_priority();
    d_req = 1;
    d_we = 1;
    d_addr = 16'h0040;
    i_req = 1;
    i_addr = 16'h0020;
    tick();
    for (int k = 0; k < 16; k++) begin
      total_n++;
      if ({d_grant, i_grant, mem_write, mem_read} !== 4'b1010 || mem_addr !== 16'h0040 + 16'(k / 4))
        $display("FAIL d_wb[%0d]: got %b addr %h want 1010 addr %h", k, {d_grant, i_grant, mem_write, mem_read}, mem_addr, 16'h0040 + 16'(k / 4));
      else pass_n++;
      total_n++;
      if (d_done !== (k == 15)) $display("FAIL d_wb_done[%0d]: got %b want %b", k, d_done, k == 15); else pass_n++;
      if (k == 15) d_req = 0;
      tick();
    end
    total_n++;
    if (outs !== 27'd0) $display("FAIL d_wb_gap: got %h want 0", outs); else pass_n++;
    tick();
    total_n++;
    if (i_grant !== 1'b0) $display("FAIL i_after_d_idle: got %b want 0", i_grant); else pass_n++;
    tick();
    total_n++;
    if (i_grant !== 1'b1 || mem_addr !== 16'h0020 || mem_read !== 1'b1)
      $display("FAIL i_after_d_start: got g=%b addr=%h want g=1 addr=0020", i_grant, mem_addr);
    else pass_n++;
    repeat (15) tick();
    total_n++;
    if (i_done !== 1'b1) $display("FAIL i_after_d_done: got %b want 1", i_done); else pass_n++;
    i_req = 0;
    tick();
    tick();
  endtask

  task automatic test_dma_turn();
    d_req = 1;
    d_we = 0;
    d_addr = 16'h0080;
    i_req = 1;
    i_addr = 16'h0030;
    tick();
    total_n++;
    if (d_grant !== 1'b1 || mem_read !== 1'b1) $display("FAIL dma_d_start: got %b%b want 11", d_grant, mem_read); else pass_n++;
    repeat (4) tick();
    br = 1;
    repeat (11) tick();
    total_n++;
    if (d_done !== 1'b1 || bg !== 1'b0) $display("FAIL dma_d_done: got done=%b bg=%b want 1 0", d_done, bg); else pass_n++;
    d_req = 0;
    tick();
    total_n++;
    if (outs !== 27'd0) $display("FAIL dma_gap: got %h want 0", outs); else pass_n++;
    tick();
    tick();
    total_n++;
    if (bg !== 1'b1 || i_grant !== 1'b0) $display("FAIL dma_beats_i: got bg=%b ig=%b want 1 0", bg, i_grant); else pass_n++;
    for (int k = 0; k < 11; k++) begin
      d_req = k[0];
      i_req = ~k[1];
      tick();
      total_n++;
      if ({bg, d_grant, i_grant, mem_read, mem_write} !== 5'b10000)
        $display("FAIL dma_hold[%0d]: got %b want 10000", k, {bg, d_grant, i_grant, mem_read, mem_write});
      else pass_n++;
    end
    d_req = 0;
    i_req = 1;
    br = 0;
    total_n++;
    if (bg !== 1'b1) $display("FAIL dma_br_fall_same: got %b want 1", bg); else pass_n++;
    tick();
    total_n++;
    if (outs !== 27'd0) $display("FAIL dma_release_gap: got %h want 0", outs); else pass_n++;
    tick();
    tick();
    total_n++;
    if (i_grant !== 1'b1 || mem_addr !== 16'h0030) $display("FAIL dma_then_i: got g=%b addr=%h want 1 0030", i_grant, mem_addr); else pass_n++;
  endtask

  task automatic test_reset_mid();
    repeat (5) tick();
    total_n++;
    if (word_idx !== 2'd1 || i_grant !== 1'b1) $display("FAIL mid_word2: got idx=%0d g=%b want 1 1", word_idx, i_grant); else pass_n++;
    reset = 1;
    i_req = 0;
    tick();
    reset = 0;
    total_n++;
    if (outs !== 27'd0) $display("FAIL reset_mid_xfer: got %h want 0", outs); else pass_n++;
    d_req = 1;
    d_addr = 16'h0100;
    tick();
    total_n++;
    if (d_grant !== 1'b1 || word_idx !== 2'd0 || mem_addr !== 16'h0100)
      $display("FAIL restart_idx0: got g=%b idx=%0d addr=%h want 1 0 0100", d_grant, word_idx, mem_addr);
    else pass_n++;
    d_req = 0;
    reset = 1;
    tick();
    reset = 0;
    br = 1;
    tick();
    tick();
    total_n++;
    if (bg !== 1'b1) $display("FAIL dma_before_reset: got %b want 1", bg); else pass_n++;
    reset = 1;
    tick();
    reset = 0;
    total_n++;
    if (outs !== 27'd0) $display("FAIL reset_mid_dma: got %h want 0", outs); else pass_n++;
    br = 0;
    tick();
    d_req = 1;
    d_addr = 16'h0200;
    tick();
    br = 1;
    repeat (15) tick();
    total_n++;
    if (d_done !== 1'b1) $display("FAIL turn_setup_done: got %b want 1", d_done); else pass_n++;
    d_req = 0;
    reset = 1;
    tick();
    reset = 0;
    d_req = 1;
    tick();
    total_n++;
    if (d_grant !== 1'b1 || bg !== 1'b0) $display("FAIL reset_clears_turn: got dg=%b bg=%b want 1 0", d_grant, bg); else pass_n++;
    d_req = 0;
    br = 0;
    reset = 1;
    tick();
    reset = 0;
  endtask

  task automatic test_lat1_bw8();
    i2_req = 1;
    i2_addr = 16'h0035;
    tick();
    for (int k = 0; k < 8; k++) begin
      total_n++;
      if ({i_grant2, word_valid2, mem_read2} !== 3'b111 || word_idx2 !== 3'(k) || mem_addr2 !== 16'h0030 + 16'(k))
        $display("FAIL lat1_word[%0d]: got %b idx=%0d addr=%h want 111 %0d %h", k, {i_grant2, word_valid2, mem_read2}, word_idx2, mem_addr2, k, 16'h0030 + 16'(k));
      else pass_n++;
      total_n++;
      if (i_done2 !== (k == 7)) $display("FAIL lat1_done[%0d]: got %b want %b", k, i_done2, k == 7); else pass_n++;
      if (k == 7) i2_req = 0;
      tick();
    end
    total_n++;
    if ({i_grant2, word_valid2, mem_addr2} !== 18'd0) $display("FAIL lat1_gap: got %b want 0", {i_grant2, word_valid2}); else pass_n++;
  endtask

  initial begin
    test_reset();
    test_i_fill();
    test_d_priority();
    test_dma_turn();
    test_reset_mid();
    test_lat1_bw8();
    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end
endmodule
